// File: rtl/fsic_io_serdes_tx.sv
// ---------------------------------------------------------------------------
// fsic_io_serdes_tx
//
// Per-lane transmit serializer for the FSIC IO SERDES. Parallel words enter
// through a valid/ready handshake into a small TX FIFO and are shifted out
// LSB-first on one serial lane, one bit per ioclk. A free-running word-phase
// counter (tx_phase) frames the words so the matching receiver can find the
// word boundaries. When the FIFO runs dry an all-zero idle word is sent
// instead and counted in underflow_cnt.
//
// Ports:
//   ioclk            in   serial bit clock (the only clock)
//   axis_rst_n       in   asynchronous active-low reset
//   txen             in   transmit enable; dropping it aborts the current word
//   flush            in   synchronous FIFO clear, wins over push and pop
//   in_valid         in   parallel word valid
//   in_data          in   parallel word, bit 0 is sent first
//   in_ready         out  FIFO has room for a word
//   serial_data_out  out  serial lane bit
//   tx_phase         out  bit index currently on serial_data_out
//   word_start       out  high while bit 0 of a word is on the lane
//   fifo_level       out  current FIFO occupancy
//   underflow_cnt    out  number of idle words inserted, saturates at 255
// ---------------------------------------------------------------------------
module fsic_io_serdes_tx #(
  parameter int pCLK_RATIO    = 4,
  parameter int pTxFIFO_DEPTH = 4
) (
  input  logic                             ioclk,
  input  logic                             axis_rst_n,
  input  logic                             txen,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [pCLK_RATIO-1:0]            in_data,
  output logic                             in_ready,
  output logic                             serial_data_out,
  output logic [$clog2(pCLK_RATIO)-1:0]    tx_phase,
  output logic                             word_start,
  output logic [$clog2(pTxFIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                       underflow_cnt
);

  localparam int PW = $clog2(pCLK_RATIO);
  localparam int AW = $clog2(pTxFIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [PW-1:0] LastPhase = PW'(pCLK_RATIO - 1);
  localparam logic [LW-1:0] FullLevel = LW'(pTxFIFO_DEPTH);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Serializer state
  state_e                  state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [pCLK_RATIO-1:0]   shift_q, shift_d;
  logic [7:0]              ucnt_q,  ucnt_d;

  // FIFO state
  logic [pCLK_RATIO-1:0]   fifoMem [pTxFIFO_DEPTH];
  logic [AW-1:0]           wrPtr_q, wrPtr_d;
  logic [AW-1:0]           rdPtr_q, rdPtr_d;
  logic [LW-1:0]           level_q, level_d;

  // Handshake / control strobes
  logic                    fifoEmpty;
  logic                    pushEn;
  logic                    popEn;
  logic                    loadEdge;
  logic [pCLK_RATIO-1:0]   headWord;

  assign fifoEmpty = (level_q == '0);
  assign headWord  = fifoMem[rdPtr_q];

  // in_ready comes straight from the registered level, so a full FIFO refuses
  // a push even when the serializer pops in the same cycle. Flush also
  // swallows any push offered alongside it.
  assign in_ready = (level_q != FullLevel);
  assign pushEn   = in_valid && in_ready && !flush;

  // ---------------------------------------------------------------------------
  // Serializer next-state logic. A word boundary ("load edge") happens on the
  // STOP->RUN edge and on every RUN edge where the phase counter is at its
  // last value. At a load edge the FIFO head is taken if there is one,
  // otherwise an all-zero idle word goes out and the underflow counter bumps.
  // A load edge coinciding with flush cannot pop, so it sends an idle word.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    shift_d  = shift_q;
    ucnt_d   = ucnt_q;
    loadEdge = 1'b0;
    popEn    = 1'b0;

    case (state_q)
      STOP: begin
        phase_d = LastPhase;
        shift_d = '0;
        if (txen) begin
          state_d  = RUN;
          loadEdge = 1'b1;
        end
      end
      RUN: begin
        if (!txen) begin
          // Abort: the in-flight word is dropped, FIFO contents stay put
          state_d = STOP;
          phase_d = LastPhase;
          shift_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
          if (phase_q == LastPhase) begin
            loadEdge = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
          end
        end
      end
      default: begin
        state_d = STOP;
        phase_d = LastPhase;
        shift_d = '0;
      end
    endcase

    if (loadEdge) begin
      phase_d = '0;
      if (!fifoEmpty && !flush) begin
        shift_d = headWord;
        popEn   = 1'b1;
      end else begin
        shift_d = '0;
        if (ucnt_q != 8'hFF) begin
          ucnt_d = ucnt_q + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointer and level update. Depth is a power of two, so the pointers
  // wrap naturally on overflow of their AW-bit width.
  // ---------------------------------------------------------------------------
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;

    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = '0;
    end else begin
      if (pushEn) begin
        wrPtr_d = wrPtr_q + AW'(1);
      end
      if (popEn) begin
        rdPtr_d = rdPtr_q + AW'(1);
      end
      if (pushEn && !popEn) begin
        level_d = level_q + LW'(1);
      end else if (popEn && !pushEn) begin
        level_d = level_q - LW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because the level gates every read
  always_ff @(posedge ioclk) begin
    if (pushEn) begin
      fifoMem[wrPtr_q] <= in_data;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q <= STOP;
      phase_q <= LastPhase;
      shift_q <= '0;
      ucnt_q  <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      shift_q <= shift_d;
      ucnt_q  <= ucnt_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // The lane bit is the registered shift LSB; in STOP the register is zero
  assign serial_data_out = shift_q[0];
  assign tx_phase        = phase_q;
  assign word_start      = (state_q == RUN) && (phase_q == '0);
  assign fifo_level      = level_q;
  assign underflow_cnt   = ucnt_q;

endmodule

// File: tb/tb_fsic_io_serdes_tx.sv
// ---------------------------------------------------------------------------
// tb_fsic_io_serdes_tx
//
// Directed bench for fsic_io_serdes_tx with pCLK_RATIO=4, pTxFIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling edge of ioclk; the
// design updates on the rising edge. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_fsic_io_serdes_tx;

  logic       ioclk;
  logic       axis_rst_n;
  logic       txen;
  logic       flush;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       serial_data_out;
  logic [1:0] tx_phase;
  logic       word_start;
  logic [2:0] fifo_level;
  logic [7:0] underflow_cnt;

  int testCount = 0;
  int failCount = 0;

  fsic_io_serdes_tx #(
    .pCLK_RATIO    (4),
    .pTxFIFO_DEPTH (4)
  ) dut (
    .ioclk           (ioclk),
    .axis_rst_n      (axis_rst_n),
    .txen            (txen),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .serial_data_out (serial_data_out),
    .tx_phase        (tx_phase),
    .word_start      (word_start),
    .fifo_level      (fifo_level),
    .underflow_cnt   (underflow_cnt)
  );

  // 10 ns ioclk, rising edges at 5, 15, 25 ...
  initial ioclk = 1'b0;
  always #5 ioclk = ~ioclk;

  // Advance one ioclk cycle, landing on the falling edge
  task automatic step();
    @(posedge ioclk);
    @(negedge ioclk);
  endtask

  // Drive the handshake and control inputs for the next rising edge
  task automatic applyStimulus(input logic valid, input logic [3:0] data,
                               input logic fl, input logic en);
    in_valid = valid;
    in_data  = data;
    flush    = fl;
    txen     = en;
  endtask

  // One comparison; counts it and reports a failure
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Check a whole word on the lane starting at its bit-0 cycle; returns on
  // the bit-3 cycle so the caller controls what happens at the next edge
  task automatic checkWord(input string tag, input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, "_lane"},  {31'd0, serial_data_out}, {31'd0, w[i]});
      checkOutput({tag, "_phase"}, {30'd0, tx_phase}, i);
      checkOutput({tag, "_wstart"}, {31'd0, word_start}, {31'd0, (i == 0)});
      if (i < 3) step();
    end
  endtask

  initial begin
    logic [3:0] fullWords [5];
    fullWords[0] = 4'h1;
    fullWords[1] = 4'h2;
    fullWords[2] = 4'h4;
    fullWords[3] = 4'h8;
    fullWords[4] = 4'hE;

    // Reset state
    axis_rst_n = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    step();
    checkOutput("rst_level",  {29'd0, fifo_level}, 0);
    checkOutput("rst_ready",  {31'd0, in_ready}, 1);
    checkOutput("rst_lane",   {31'd0, serial_data_out}, 0);
    checkOutput("rst_phase",  {30'd0, tx_phase}, 3);
    checkOutput("rst_wstart", {31'd0, word_start}, 0);
    checkOutput("rst_ucnt",   {24'd0, underflow_cnt}, 0);
    axis_rst_n = 1'b1;
    step();

    // Basic sequence: A then 5 pushed before the first load edge
    applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
    step();
    checkOutput("basic_level2", {29'd0, fifo_level}, 2);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    step();
    checkWord("basicA", 4'hA);
    step();
    checkOutput("basic_ucnt", {24'd0, underflow_cnt}, 0);
    checkOutput("basic_level0", {29'd0, fifo_level}, 0);
    checkWord("basic5", 4'h5);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    step();
    checkOutput("stop_lane",  {31'd0, serial_data_out}, 0);
    checkOutput("stop_phase", {30'd0, tx_phase}, 3);
    checkOutput("stop_ucnt",  {24'd0, underflow_cnt}, 0);

    // Underflow: three idle words, then F pushed mid-word goes out next
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    step();
    checkWord("idle1", 4'h0);
    step();
    checkWord("idle2", 4'h0);
    step();
    checkOutput("uf_ucnt3", {24'd0, underflow_cnt}, 3);
    checkOutput("uf_lane",  {31'd0, serial_data_out}, 0);
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("uf_levelF", {29'd0, fifo_level}, 1);
    step();
    step();
    checkOutput("uf_idle3_ph3", {31'd0, serial_data_out}, 0);
    step();
    checkWord("wordF", 4'hF);
    checkOutput("uf_ucnt_hold", {24'd0, underflow_cnt}, 3);

    // Push lands on the exact load edge with an empty FIFO
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("sim_ucnt4",  {24'd0, underflow_cnt}, 4);
    checkOutput("sim_level1", {29'd0, fifo_level}, 1);
    checkWord("simIdle", 4'h0);
    step();
    checkWord("sim3", 4'h3);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    step();

    // Back-pressure: five pushes while stopped, only four accepted
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, fullWords[i], 1'b0, 1'b0);
      checkOutput($sformatf("full_ready%0d", i), {31'd0, in_ready}, {31'd0, (i < 4)});
      step();
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("full_level", {29'd0, fifo_level}, 4);
    checkOutput("full_ready", {31'd0, in_ready}, 0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    step();
    checkOutput("full_level3", {29'd0, fifo_level}, 3);
    checkWord("full0", fullWords[0]);
    step();
    checkWord("full1", fullWords[1]);
    step();
    checkWord("full2", fullWords[2]);
    step();
    checkWord("full3", fullWords[3]);
    step();
    checkOutput("full_ucnt5", {24'd0, underflow_cnt}, 5);
    checkWord("fullIdle", 4'h0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    step();

    // Abort after bit 1 of C with 9 queued; 9 goes first on re-enable
    applyStimulus(1'b1, 4'hC, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    step();
    checkOutput("abort_ph0", {30'd0, tx_phase}, 0);
    step();
    checkOutput("abort_ph1", {30'd0, tx_phase}, 1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    step();
    checkOutput("abort_lane",  {31'd0, serial_data_out}, 0);
    checkOutput("abort_phase", {30'd0, tx_phase}, 3);
    checkOutput("abort_level", {29'd0, fifo_level}, 1);
    step();
    checkOutput("abort_hold_phase", {30'd0, tx_phase}, 3);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    step();
    checkWord("resume9", 4'h9);
    checkOutput("abort_ucnt", {24'd0, underflow_cnt}, 5);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    step();

    // Flush with three queued words, push offered in the flush cycle is dropped
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
      step();
    end
    checkOutput("flush_pre", {29'd0, fifo_level}, 3);
    applyStimulus(1'b1, 4'h7, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("flush_level", {29'd0, fifo_level}, 0);
    checkOutput("flush_ready", {31'd0, in_ready}, 1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    step();
    checkWord("flushIdle", 4'h0);
    checkOutput("flush_ucnt6", {24'd0, underflow_cnt}, 6);

    // 300 idle words: the counter must pin at 255
    repeat (1200) step();
    checkOutput("sat_ucnt", {24'd0, underflow_cnt}, 255);
    checkOutput("sat_phase", {30'd0, tx_phase}, 3);

    // Reset in the middle of word F with A still queued
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
    step();
    applyStimulus(1'b1, 4'hA, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    step();
    step();
    step();
    checkOutput("mid_lane0", {31'd0, serial_data_out}, 1);
    checkOutput("mid_level", {29'd0, fifo_level}, 1);
    step();
    checkOutput("mid_lane1", {31'd0, serial_data_out}, 1);
    #2 axis_rst_n = 1'b0;
    #1;
    checkOutput("mrst_lane",   {31'd0, serial_data_out}, 0);
    checkOutput("mrst_phase",  {30'd0, tx_phase}, 3);
    checkOutput("mrst_wstart", {31'd0, word_start}, 0);
    checkOutput("mrst_level",  {29'd0, fifo_level}, 0);
    checkOutput("mrst_ready",  {31'd0, in_ready}, 1);
    checkOutput("mrst_ucnt",   {24'd0, underflow_cnt}, 0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    step();
    axis_rst_n = 1'b1;
    step();
    step();
    checkOutput("post_lane",  {31'd0, serial_data_out}, 0);
    checkOutput("post_phase", {30'd0, tx_phase}, 3);
    checkOutput("post_ucnt",  {24'd0, underflow_cnt}, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/fsic_io_serdes_tx.md
Name: fsic_io_serdes_tx

Overview:
Per-lane transmit serializer, the counterpart of the per-lane receiver (fsic_io_serdes_rx) in the FSIC IO SERDES. It accepts pCLK_RATIO-bit parallel words through a valid/ready handshake and buffers them in a small TX FIFO. Each word is shifted out LSB-first on one serial lane, one bit per ioclk, phase-aligned to a free-running word-phase counter. IO_SERDES instantiates one copy per serial lane: tdata nibbles, tstrb, tkeep, tid_tuser and tlast_tvalid_tready.

Parameters:
pCLK_RATIO, 4, bits per word = ioclk cycles per word; power of two, >=2
pTxFIFO_DEPTH, 4, TX FIFO entries; power of two, >=2

Ports:
ioclk  input  1  serial bit clock; the only clock
axis_rst_n  input  1  asynchronous active-low reset
txen  input  1  transmit enable, synchronous to ioclk
flush  input  1  synchronous FIFO clear; takes priority over push
in_valid  input  1  parallel word valid
in_data  input  pCLK_RATIO  parallel word; bit 0 is sent first
in_ready  output  1  FIFO can accept a word
serial_data_out  output  1  serial lane bit
tx_phase  output  $clog2(pCLK_RATIO)  bit index currently on serial_data_out
word_start  output  1  high in the cycle bit 0 of a word is on the lane
fifo_level  output  $clog2(pTxFIFO_DEPTH)+1  current FIFO occupancy
underflow_cnt  output  8  idle words inserted because the FIFO was empty; saturates at 255

Behaviour:
- Reset values (axis_rst_n=0, asynchronous): FIFO empty, fifo_level=0, in_ready=1, shift register=0, serial_data_out=0, tx_phase=pCLK_RATIO-1, word_start=0, underflow_cnt=0.
- Clocking: all state updates on posedge ioclk.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = (fifo_level != pTxFIFO_DEPTH), from registered level.
  - Full FIFO: a push is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle: level unchanged.
  - Pointers wrap modulo pTxFIFO_DEPTH.
  - flush=1: level <= 0 and pointers reset at the next edge; push and pop are ignored that cycle; the word in the shift register continues.
- Two states, STOP and RUN.
  - STOP: serial_data_out=0, tx_phase held at pCLK_RATIO-1, no pops. Go to RUN on the edge where txen=1.
  - RUN: tx_phase <= tx_phase+1, wrapping at pCLK_RATIO.
  - RUN, at the edge where tx_phase==pCLK_RATIO-1 (this includes the STOP->RUN edge): load the next word.
    - FIFO not empty: pop the head into the shift register.
    - FIFO empty: load all zeros (idle word) and increment underflow_cnt, saturating.
  - RUN, other edges: shift the register right by one.
- Lane timing: serial_data_out = shift_reg[0], registered. After a load edge, word bits 0..pCLK_RATIO-1 appear in the next pCLK_RATIO cycles with tx_phase = 0..pCLK_RATIO-1.
- word_start = RUN && tx_phase==0.
- Latency: a word pushed into an empty FIFO at least one cycle before a load edge has bit 0 on the lane the cycle after that load edge. Worst case pCLK_RATIO+1 cycles.
- txen falling while in RUN:
  - Next edge goes to STOP; the in-flight word is aborted.
  - Shift register cleared, serial_data_out=0, tx_phase=pCLK_RATIO-1.
  - FIFO contents retained.
- txen re-assert: the first word loaded is the FIFO head; there is no partial-word resumption.
- Reset mid-word: all state is cleared immediately; nothing is sent after reset release until txen=1.

Test Plan:
- Basic sequence, pCLK_RATIO=4: push 4'hA then 4'h5 with txen=1 from reset. Lane shows 0,1,0,1 then 1,0,1,0. word_start is high on the 1st and 5th bit. underflow_cnt=0 if pushed before the first load edge.
- Underflow: txen=1 with an empty FIFO for 3 words. Lane all 0, underflow_cnt=3. Then push 4'hF: next word on the lane is 1,1,1,1.
- Full/back-pressure, pTxFIFO_DEPTH=4, txen=0: push 5 words. in_ready=0 after the 4th, the 5th is not accepted, fifo_level=4. Set txen=1: exactly 4 words are sent, in order.
- Simultaneous push and load: push 4'h3 on the exact load edge with the FIFO empty. An idle word is sent and underflow_cnt increments; 4'h3 is sent in the next word slot.
- Abort: drop txen after bit 1 of word 4'hC, with 4'h9 queued. Lane goes 0, tx_phase=3. On re-enable the lane sends 4'h9 (1,0,0,1) first.
- Flush and saturation: flush with 3 words queued gives fifo_level=0 next cycle. Run 300 idle words: underflow_cnt holds at 255. Assert reset mid-word: all outputs return to reset values immediately.
